// File: rtl/matrix_uart_formatter.sv
// rtl/matrix_uart_formatter.sv - streams a runtime-sized matrix as right-aligned ASCII over a byte UART handshake
module matrix_uart_formatter #(
   parameter int DATA_WIDTH = 9,
   parameter int MAX_ROWS   = 8,
   parameter int MAX_COLS   = 10,
   parameter int NUM_DIGITS = 3,
   parameter int CRLF       = 0
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     start,
   input  logic                                     abort,
   input  logic [3:0]                               rows,
   input  logic [3:0]                               cols,
   input  logic                                     signed_en,
   input  logic [MAX_ROWS*MAX_COLS*DATA_WIDTH-1:0]  data_flat,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err,
   input  logic                                     tx_busy,
   output logic                                     tx_start,
   output logic [7:0]                               tx_data
);

   localparam int KW    = (MAX_ROWS * MAX_COLS > 1) ? $clog2(MAX_ROWS * MAX_COLS) : 1;
   localparam int BW    = $clog2(DATA_WIDTH + 1);
   localparam int CW    = $clog2(NUM_DIGITS + 4);
   localparam int BCD_W = 4 * NUM_DIGITS;

   localparam logic [3:0]    MAX_ROWS_L = 4'(MAX_ROWS);
   localparam logic [3:0]    MAX_COLS_L = 4'(MAX_COLS);
   localparam logic [CW-1:0] TERM_LEN   = CW'(1 + CRLF);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_CONVERT,
      S_EMIT,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT,
      S_FINISH,
      S_ERR
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic                  r_start_d;
   logic [3:0]            r_rows;
   logic [3:0]            r_cols;
   logic                  r_signed;
   logic [3:0]            r_r;
   logic [3:0]            r_c;
   logic [KW-1:0]         r_k;
   logic                  r_neg;
   logic [DATA_WIDTH-1:0] r_bin;
   logic [BCD_W-1:0]      r_bcd;
   logic [BW-1:0]         r_bit;
   logic [CW-1:0]         r_ci;
   logic                  r_abort_pend;
   logic                  r_tx_start;
   logic [7:0]            r_tx_data;

   logic                  w_start_edge;
   logic                  w_dim_bad;
   logic [DATA_WIDTH-1:0] w_elem;
   logic                  w_neg;
   logic [DATA_WIDTH-1:0] w_mag;
   logic [BCD_W-1:0]      w_bcd_adj;
   logic [BCD_W-1:0]      w_bcd_next;
   logic [CW-1:0]         w_lead;
   logic                  w_found;
   logic [CW-1:0]         w_field;
   logic [CW-1:0]         w_total;
   logic [CW-1:0]         w_msd_pos;
   logic [CW-1:0]         w_dig_idx;
   logic                  w_last_col;
   logic                  w_last_row;
   logic [7:0]            w_byte;

   assign w_start_edge = start & ~r_start_d;
   assign w_dim_bad    = (r_rows == 4'd0) || (r_rows > MAX_ROWS_L) ||
                         (r_cols == 4'd0) || (r_cols > MAX_COLS_L);

   // Element k is dense row-major, so a running index avoids a multiplier.
   assign w_elem = data_flat[r_k * DATA_WIDTH +: DATA_WIDTH];
   assign w_neg  = r_signed & w_elem[DATA_WIDTH-1];
   // The most negative input negates to 2^(DATA_WIDTH-1), which still fits the unsigned magnitude width.
   assign w_mag  = w_neg ? (~w_elem + 1'b1) : w_elem;

   assign w_last_col = (r_c == r_cols - 4'd1);
   assign w_last_row = (r_r == r_rows - 4'd1);
   assign w_field    = CW'(NUM_DIGITS) + CW'(r_signed);
   assign w_total    = w_field + (w_last_col ? TERM_LEN : CW'(1));
   assign w_msd_pos  = w_lead + CW'(r_signed);

   assign busy     = (r_state != S_IDLE) && (r_state != S_FINISH) && (r_state != S_ERR);
   assign done     = (r_state == S_FINISH);
   assign err      = (r_state == S_ERR);
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;

   // Double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      w_bcd_next = (w_bcd_adj << 1) | BCD_W'(r_bin[DATA_WIDTH-1]);
   end

   // Count leading zero digits; a zero value keeps its units digit.
   always_comb begin
      w_lead  = CW'(NUM_DIGITS - 1);
      w_found = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (!w_found && (r_bcd[4*(NUM_DIGITS-1-j) +: 4] != 4'd0)) begin
            w_lead  = CW'(j);
            w_found = 1'b1;
         end
      end
   end

   // Character at position r_ci of the current element's field plus separator/terminator.
   always_comb begin
      w_byte    = 8'd32;
      w_dig_idx = '0;
      if (r_ci < w_field) begin
         if (r_ci < w_msd_pos) begin
            if (r_neg && (r_ci == w_msd_pos - CW'(1))) begin
               w_byte = 8'd45;
            end
         end else begin
            w_dig_idx = r_ci - CW'(r_signed);
            w_byte    = 8'h30 + {4'd0, r_bcd[4*(NUM_DIGITS-1-int'(w_dig_idx)) +: 4]};
         end
      end else if (!w_last_col) begin
         w_byte = 8'd32;
      end else if ((CRLF != 0) && (r_ci == w_field)) begin
         w_byte = 8'd13;
      end else begin
         w_byte = 8'd10;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; abort jumps to ERR unless a byte is in flight.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_edge) w_next = S_CHECK;
         S_CHECK:   w_next = (abort || w_dim_bad) ? S_ERR : S_LOAD;
         S_LOAD:    w_next = abort ? S_ERR : S_CONVERT;
         S_CONVERT: begin
            if (abort)                  w_next = S_ERR;
            else if (r_bit == LAST_BIT) w_next = S_EMIT;
         end
         S_EMIT:    w_next = abort ? S_ERR : S_SEND;
         S_SEND: begin
            if (abort)         w_next = S_ERR;
            else if (!tx_busy) w_next = S_WAIT_HI;
         end
         S_WAIT_HI: if (tx_busy) w_next = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (abort || r_abort_pend)          w_next = S_ERR;
               else if (r_ci == w_total - CW'(1))  w_next = S_NEXT;
               else                                w_next = S_EMIT;
            end
         end
         S_NEXT: begin
            if (abort)                         w_next = S_ERR;
            else if (w_last_row && w_last_col) w_next = S_FINISH;
            else                               w_next = S_LOAD;
         end
         S_FINISH:  w_next = S_IDLE;
         S_ERR:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Datapath: start capture, element load, BCD conversion, byte strobe and position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_d    <= 1'b0;
         r_rows       <= '0;
         r_cols       <= '0;
         r_signed     <= 1'b0;
         r_r          <= '0;
         r_c          <= '0;
         r_k          <= '0;
         r_neg        <= 1'b0;
         r_bin        <= '0;
         r_bcd        <= '0;
         r_bit        <= '0;
         r_ci         <= '0;
         r_abort_pend <= 1'b0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
      end else begin
         r_start_d  <= start;
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_abort_pend <= 1'b0;
               if (w_start_edge) begin
                  r_rows   <= rows;
                  r_cols   <= cols;
                  r_signed <= signed_en;
                  r_r      <= '0;
                  r_c      <= '0;
                  r_k      <= '0;
               end
            end
            S_LOAD: begin
               r_neg <= w_neg;
               r_bin <= w_mag;
               r_bcd <= '0;
               r_bit <= '0;
               r_ci  <= '0;
            end
            S_CONVERT: begin
               r_bcd <= w_bcd_next;
               r_bin <= r_bin << 1;
               r_bit <= r_bit + BW'(1);
            end
            S_SEND: begin
               if (!tx_busy && !abort) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= w_byte;
               end
            end
            S_WAIT_HI: begin
               if (abort) r_abort_pend <= 1'b1;
            end
            S_WAIT_LO: begin
               if (abort)    r_abort_pend <= 1'b1;
               if (!tx_busy) r_ci <= r_ci + CW'(1);
            end
            S_NEXT: begin
               r_k <= r_k + KW'(1);
               if (w_last_col) begin
                  r_c <= '0;
                  r_r <= r_r + 4'd1;
               end else begin
                  r_c <= r_c + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
